// File: rtl/hdlverifier_capture_comparator_nbit_if.sv
// Bus bundle for the N-bit capture comparator: sample stream, trigger setup and the
// match/trigger status returned by the comparator.
interface hdlverifier_capture_comparator_nbit_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic                   clk_enable;
  logic [DATA_WIDTH-1:0]  data;
  logic [DATA_WIDTH-1:0]  trigger_value;
  logic [DATA_WIDTH-1:0]  trigger_mask;
  logic [2:0]             trigger_mode;
  logic [2:0]             trigger_comparison_operator;
  logic [COUNT_WIDTH-1:0] trigger_count;
  logic                   arm;
  logic                   match;
  logic                   trigger;
  logic                   triggered;

  modport master (
    output clk_enable, data, trigger_value, trigger_mask, trigger_mode,
           trigger_comparison_operator, trigger_count, arm,
    input  match, trigger, triggered
  );

  modport slave (
    input  clk_enable, data, trigger_value, trigger_mask, trigger_mode,
           trigger_comparison_operator, trigger_count, arm,
    output match, trigger, triggered
  );
endinterface

// File: rtl/hdlverifier_capture_comparator_nbit.sv
// N-bit capture comparator: masked relational/edge qualification, consecutive-run
// counting and an arm/trigger state machine that starts data capture.
//
//   state     | meaning
//   IDLE      | not armed, qualified samples ignored
//   ARMED     | searching for the first qualified sample of a run
//   COUNTING  | inside a run of qualified samples, counter < required
//   TRIGGERED | trigger has fired, waiting for the next arm
module hdlverifier_capture_comparator_nbit #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input logic clk,
  input logic reset_n,
  hdlverifier_capture_comparator_nbit_if.slave cmp
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] COUNTING  = 2'd2;
  localparam logic [1:0] TRIGGERED = 2'd3;

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0]  data_d1;
  logic                   cond_d1;
  logic                   hist_valid;

  logic [DATA_WIDTH-1:0]  md;
  logic [DATA_WIDTH-1:0]  mv;
  logic                   cond;
  logic                   qual;
  logic [COUNT_WIDTH-1:0] required;
  logic [COUNT_WIDTH:0]   cnt_inc;
  logic                   run_done;

  always_comb begin
    md = cmp.data & cmp.trigger_mask;
    mv = cmp.trigger_value & cmp.trigger_mask;
    cond = 1'b0;
    case (cmp.trigger_comparison_operator)
      3'd0:    cond = (md == mv);
      3'd1:    cond = (md != mv);
      3'd2:    cond = (md <  mv);
      3'd3:    cond = (md <= mv);
      3'd4:    cond = (md >  mv);
      3'd5:    cond = (md >= mv);
      default: cond = 1'b0;
    endcase
  end

  // Edge and change modes need one sample of history before they can qualify.
  always_comb begin
    qual = 1'b0;
    case (cmp.trigger_mode)
      3'd0:    qual = cond;
      3'd1:    qual = hist_valid & ~cond_d1 & cond;
      3'd2:    qual = hist_valid & cond_d1 & ~cond;
      3'd3:    qual = hist_valid & (|((cmp.data ^ data_d1) & cmp.trigger_mask));
      default: qual = 1'b0;
    endcase
  end

  // >= rather than == so a count lowered mid-run fires on the next qualified sample.
  always_comb begin
    required = (cmp.trigger_count == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : cmp.trigger_count;
    cnt_inc  = {1'b0, counter} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    run_done = (cnt_inc >= {1'b0, required});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      counter       <= '0;
      data_d1       <= '0;
      cond_d1       <= 1'b0;
      hist_valid    <= 1'b0;
      cmp.match     <= 1'b0;
      cmp.trigger   <= 1'b0;
      cmp.triggered <= 1'b0;
    end else begin
      cmp.trigger <= 1'b0;
      if (cmp.clk_enable) begin
        data_d1    <= cmp.data;
        cond_d1    <= cond;
        hist_valid <= 1'b1;
        cmp.match  <= qual;
      end
      // arm overrides everything, including a run completing on this very edge
      if (cmp.arm) begin
        state         <= ARMED;
        counter       <= '0;
        cmp.triggered <= 1'b0;
      end else if (cmp.clk_enable) begin
        case (state)
          ARMED, COUNTING: begin
            if (qual) begin
              if (run_done) begin
                counter       <= required;
                state         <= TRIGGERED;
                cmp.trigger   <= 1'b1;
                cmp.triggered <= 1'b1;
              end else begin
                counter <= cnt_inc[COUNT_WIDTH-1:0];
                state   <= COUNTING;
              end
            end else begin
              counter <= '0;
              state   <= ARMED;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
